// File: rtl/cntr_ctrl_if.sv
// Control/status bundle for the prescaled counter: run controls in, count and pulses out.
interface cntr_ctrl_if #(
    parameter int COUNT_WIDTH    = 4,
    parameter int PRESCALE_WIDTH = 4
);
    logic                      start;
    logic                      stop;
    logic                      pause;
    logic                      auto_reload;
    logic [COUNT_WIDTH-1:0]    limit;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [COUNT_WIDTH-1:0]    count;
    logic                      tick;
    logic                      done;
    logic                      busy;

    modport master (
        output start, stop, pause, auto_reload, limit, prescale,
        input  count, tick, done, busy
    );

    modport slave (
        input  start, stop, pause, auto_reload, limit, prescale,
        output count, tick, done, busy
    );
endinterface

// File: rtl/cntr_ctrl.sv
// Prescaled up-counter with one-shot/periodic modes, pause and abort; all outputs registered.
module cntr_ctrl #(
    parameter int COUNT_WIDTH    = 4,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    cntr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic [COUNT_WIDTH-1:0]    limit_q, limit_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      reload_q, reload_d;
    logic                      tick_q, tick_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;

    logic pre_wrap;
    logic at_limit;
    logic term_tick;

    assign pre_wrap  = (pre_q == prescale_q);
    assign at_limit  = (count_q == limit_q);
    // A terminal tick in RUN completes even when pause arrives on the same cycle.
    assign term_tick = (state_q == S_RUN) && pre_wrap && at_limit;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_d      = pre_q;
        limit_d    = limit_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        if (bus.stop) begin
            state_d = S_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        limit_d    = bus.limit;
                        prescale_d = bus.prescale;
                        reload_d   = bus.auto_reload;
                        count_d    = '0;
                        pre_d      = '0;
                        state_d    = S_RUN;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (bus.pause && !term_tick) begin
                        state_d = S_HOLD;
                    end else begin
                        // Leaving HOLD advances on the same edge so a pause costs exactly its length.
                        state_d = S_RUN;
                        if (pre_wrap) begin
                            pre_d  = '0;
                            tick_d = 1'b1;
                            if (at_limit) begin
                                done_d = 1'b1;
                                if (reload_q) begin
                                    count_d = '0;
                                    state_d = bus.pause ? S_HOLD : S_RUN;
                                end else begin
                                    state_d = S_DONE;
                                end
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            pre_q      <= '0;
            limit_q    <= '0;
            prescale_q <= '0;
            reload_q   <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: doc/cntr_ctrl.md
CNTR_CTRL -- requirements
Module: cntr_ctrl

Interface
REQ-001 Parameter COUNT_WIDTH, default 4, SHALL set the counter and limit width in bits.
REQ-002 Parameter PRESCALE_WIDTH, default 4, SHALL set the prescaler and prescale width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL be a request to arm and run the counter.
REQ-006 stop  input  1  SHALL be an abort request that returns the block to idle.
REQ-007 pause  input  1  SHALL be a level input that freezes counting while high.
REQ-008 auto_reload  input  1  SHALL select periodic mode (1) or one-shot mode (0); sampled on start.
REQ-009 limit  input  COUNT_WIDTH  SHALL be the terminal count value; sampled on start.
REQ-010 prescale  input  PRESCALE_WIDTH  SHALL set the divide ratio: one tick every prescale+1 clk cycles; sampled on start.
REQ-011 count  output  COUNT_WIDTH  SHALL be the current counter value.
REQ-012 tick  output  1  SHALL be a one-cycle pulse marking each count advance.
REQ-013 done  output  1  SHALL be a one-cycle pulse marking each terminal count.
REQ-014 busy  output  1  SHALL be high while in the RUN or HOLD states.

Function
REQ-015 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-016 The FSM SHALL have four states, IDLE, RUN, HOLD and DONE, with an internal prescaler register pre.
REQ-017 Input priority SHALL be rst, then stop, then start, then pause.
REQ-018 stop in any state SHALL cause, at the next edge: state IDLE, count=0, pre=0, tick=0, done=0.
REQ-019 stop and start in the same cycle SHALL resolve to stop.
REQ-020 start in IDLE or DONE SHALL latch limit, prescale and auto_reload into shadow registers and set count=0, pre=0 and state RUN at the next edge.
REQ-021 start SHALL be ignored in RUN and HOLD.
REQ-022 Changes to limit, prescale or auto_reload after start SHALL have no effect until the next start.
REQ-023 In RUN, when pre != prescale_q, pre SHALL increment and count SHALL hold.
REQ-024 In RUN, when pre == prescale_q, at the next edge pre SHALL become 0 and tick SHALL be 1.
REQ-025 On the same edge, if count != limit_q, count SHALL increment.
REQ-026 If count == limit_q on that edge (the terminal tick), done SHALL be 1 and:
  - auto_reload_q=1: count becomes 0 and state stays RUN;
  - auto_reload_q=0: count holds at limit_q and state becomes DONE.
REQ-027 prescale_q=0 SHALL produce a tick every cycle in RUN.
REQ-028 limit_q=0 SHALL make every tick terminal.
REQ-029 The period SHALL be (limit_q+1)*(prescale_q+1) cycles.
REQ-030 count SHALL never exceed limit_q; limit_q = 2^COUNT_WIDTH-1 SHALL wrap to 0 only through reload, with no overflow.
REQ-031 RUN with pause=1 SHALL enter HOLD at the next edge, with pre and count frozen and no tick.
REQ-032 HOLD with pause=0 SHALL return to RUN, resuming from the frozen pre and count.
REQ-033 A pause that arrives in the same cycle as a terminal tick SHALL let the tick complete first, then enter HOLD (periodic mode) or DONE (one-shot mode).
REQ-034 In DONE, busy SHALL be 0 and count SHALL hold until start or stop.
REQ-035 tick and done SHALL be 0 in every cycle other than those defined above.

Reset
REQ-036 rst=1 SHALL set, at the next edge: state IDLE, count=0, pre=0, all shadow registers=0, tick=0, done=0, busy=0.
REQ-037 Reset asserted mid-RUN or mid-HOLD SHALL abort with no done pulse.
REQ-038 Reset SHALL override start and stop presented in the same cycle.

Verification
REQ-039 One-shot test SHALL apply limit=3, prescale=0, auto_reload=0, start pulsed at cycle 0, and check:
  - count reads 0,1,2,3 at cycles 1..4;
  - tick is high at cycles 2..5;
  - done is high only at cycle 5;
  - busy is high at cycles 1..4 and 0 from cycle 5, with count held at 3.
REQ-040 Periodic test SHALL apply limit=2, prescale=2, auto_reload=1 and check that done pulses every 9 cycles, count cycles 0,1,2,0 and tick pulses every 3 cycles.
REQ-041 Wrap test SHALL apply limit=15, prescale=0, auto_reload=1 and check count 15->0 with a done pulse and no value above 15.
REQ-042 Pause test SHALL hold pause high for 5 cycles mid-RUN at count=1 and check:
  - count stays 1, tick stays 0 and busy stays 1 during the pause;
  - counting resumes with the period extended by exactly 5 cycles.
REQ-043 Stop/start test SHALL assert start and stop together while in RUN and check IDLE, count=0 and busy=0 at the next cycle.
REQ-044 Limit-change test SHALL start with limit=3, drive limit to 1 while in RUN and check that the terminal count stays at 3.
REQ-045 Reset test SHALL assert rst mid-RUN and check that all outputs are 0 at the next cycle and no done pulse occurs.
